// File: rtl/cache_mem_arbiter_if.sv
// Bundles the icache, dcache and adaptor line-port signals seen by cache_mem_arbiter.
// The slave modport is the arbiter's view; master is the view of the caches plus adaptor.
interface cache_mem_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int LINE_W = 256
);
  logic [ADDR_W-1:0] i_address;
  logic              i_read;
  logic [LINE_W-1:0] i_rdata;
  logic              i_resp;

  logic [ADDR_W-1:0] d_address;
  logic              d_read;
  logic              d_write;
  logic [LINE_W-1:0] d_wdata;
  logic [LINE_W-1:0] d_rdata;
  logic              d_resp;

  logic [ADDR_W-1:0] mem_address;
  logic              mem_read;
  logic              mem_write;
  logic [LINE_W-1:0] mem_wdata;
  logic [LINE_W-1:0] mem_rdata;
  logic              mem_resp;

  modport slave (
    input  i_address, i_read, d_address, d_read, d_write, d_wdata, mem_rdata, mem_resp,
    output i_rdata, i_resp, d_rdata, d_resp, mem_address, mem_read, mem_write, mem_wdata
  );

  modport master (
    output i_address, i_read, d_address, d_read, d_write, d_wdata, mem_rdata, mem_resp,
    input  i_rdata, i_resp, d_rdata, d_resp, mem_address, mem_read, mem_write, mem_wdata
  );
endinterface

// File: rtl/cache_mem_arbiter.sv
// Shares the adaptor line port between icache (reads) and dcache (reads/writebacks).
// Define CACHE_ARB_RR_EN for round-robin arbitration; default is fixed dcache priority.
//
// Handshake: a cache holds its request until its one-cycle resp pulse. The adaptor
// sees mem_read/mem_write held high from latched state until it returns mem_resp.
module cache_mem_arbiter #(
  parameter int ADDR_W = 32,
  parameter int LINE_W = 256
) (
  input  logic                clk,
  input  logic                reset_n,
  cache_mem_arbiter_if.slave  bus,
  output logic [1:0]          o_state
);

  typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, DONE = 2'd2} state_e;
  typedef enum logic {GNT_I = 1'b0, GNT_D = 1'b1} gnt_e;

  state_e            r_state, w_next_state;
  gnt_e              r_gnt, w_win;
  logic              r_write;
  logic [ADDR_W-1:0] r_addr;
  logic [LINE_W-1:0] r_wdata;
  logic [LINE_W-1:0] r_i_rdata;
  logic [LINE_W-1:0] r_d_rdata;
  logic              w_i_req, w_d_req, w_any_req;

  assign w_i_req   = bus.i_read;
  assign w_d_req   = bus.d_read | bus.d_write;
  assign w_any_req = w_i_req | w_d_req;

`ifdef CACHE_ARB_RR_EN
  gnt_e r_last_grant;

  always_comb begin
    w_win = GNT_I;
    if (w_d_req && w_i_req) w_win = (r_last_grant == GNT_D) ? GNT_I : GNT_D;
    else if (w_d_req)       w_win = GNT_D;
  end

  always_ff @(posedge clk) begin
    if (!reset_n)                          r_last_grant <= GNT_I;
    else if (r_state == IDLE && w_any_req) r_last_grant <= w_win;
  end
`else
  always_comb begin
    w_win = w_d_req ? GNT_D : GNT_I;
  end
`endif

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state   <= IDLE;
      r_gnt     <= GNT_I;
      r_write   <= 1'b0;
      r_addr    <= '0;
      r_wdata   <= '0;
      r_i_rdata <= '0;
      r_d_rdata <= '0;
    end else begin
      r_state <= w_next_state;
      // d_read with d_write resolves to a writeback.
      if (r_state == IDLE && w_any_req) begin
        r_gnt   <= w_win;
        r_write <= (w_win == GNT_D) && bus.d_write;
        r_addr  <= (w_win == GNT_D) ? bus.d_address : bus.i_address;
        if (w_win == GNT_D && bus.d_write) r_wdata <= bus.d_wdata;
      end
      if (r_state == BUSY && bus.mem_resp) begin
        if (r_gnt == GNT_D) r_d_rdata <= bus.mem_rdata;
        else                r_i_rdata <= bus.mem_rdata;
      end
    end
  end

  always_comb begin
    w_next_state  = r_state;
    bus.mem_read  = 1'b0;
    bus.mem_write = 1'b0;
    bus.i_resp    = 1'b0;
    bus.d_resp    = 1'b0;
    unique case (r_state)
      IDLE: if (w_any_req) w_next_state = BUSY;
      BUSY: begin
        bus.mem_read  = ~r_write;
        bus.mem_write = r_write;
        if (bus.mem_resp) w_next_state = DONE;
      end
      DONE: begin
        bus.i_resp   = (r_gnt == GNT_I);
        bus.d_resp   = (r_gnt == GNT_D);
        w_next_state = IDLE;
      end
      default: w_next_state = IDLE;
    endcase
  end

  assign bus.mem_address = r_addr;
  assign bus.mem_wdata   = r_wdata;
  assign bus.i_rdata     = r_i_rdata;
  assign bus.d_rdata     = r_d_rdata;
  assign o_state         = r_state;

  a_no_read_and_write: assert property (
    @(posedge clk) disable iff (!reset_n) !(bus.d_read && bus.d_write)
  );

endmodule

// File: tb/tb_cache_mem_arbiter.sv
// Bench for cache_mem_arbiter: adaptor model, client driver tasks and a scoreboard of
// expected transactions in service order, checked at the adaptor and at each resp pulse.
module tb_cache_mem_arbiter;
  localparam int ADDR_W = 32;
  localparam int LINE_W = 256;
  localparam int EW     = LINE_W + ADDR_W + 2;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic [1:0] state;

  int checks = 0;
  int errors = 0;
  int lat = 5;
  int busy_cnt = 0;
  logic spur = 1'b0;
  logic prev_resp = 1'b0;
  logic [LINE_W-1:0] last_i = '0;
  logic [LINE_W-1:0] last_d = '0;
  logic [EW-1:0] exp_q[$];

  cache_mem_arbiter_if #(.ADDR_W(ADDR_W), .LINE_W(LINE_W)) bus();

  cache_mem_arbiter #(.ADDR_W(ADDR_W), .LINE_W(LINE_W)) dut (
    .clk(clk), .reset_n(reset_n), .bus(bus), .o_state(state)
  );

  always #5 clk = ~clk;

  // ---------------- scoreboard entry helpers ----------------
  function automatic logic [EW-1:0] mk_entry(input logic client, input logic wr,
                                             input logic [ADDR_W-1:0] a, input logic [LINE_W-1:0] w);
    return {client, wr, a, w};
  endfunction
  function automatic logic e_client(input logic [EW-1:0] e); return e[EW-1]; endfunction
  function automatic logic e_wr(input logic [EW-1:0] e); return e[EW-2]; endfunction
  function automatic logic [ADDR_W-1:0] e_addr(input logic [EW-1:0] e); return e[LINE_W +: ADDR_W]; endfunction
  function automatic logic [LINE_W-1:0] e_wdata(input logic [EW-1:0] e); return e[LINE_W-1:0]; endfunction

  function automatic logic [LINE_W-1:0] mem_line(input logic [ADDR_W-1:0] a);
    logic [LINE_W-1:0] l;
    if (a == 32'h0000_0040) l = {32{8'hA5}};
    else                    l = {8{a ^ 32'h5A5A_C3C3}};
    return l;
  endfunction

  // ---------------- adaptor model ----------------
  always @(negedge clk) begin
    logic [EW-1:0] e;
    if (bus.mem_read || bus.mem_write) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL adaptor_unexpected: mem_read=%0b mem_write=%0b addr=%h, required no request",
                 bus.mem_read, bus.mem_write, bus.mem_address);
      end else begin
        e = exp_q[0];
        if (bus.mem_address !== e_addr(e) || bus.mem_write !== e_wr(e) || bus.mem_read !== ~e_wr(e) ||
            (e_wr(e) && bus.mem_wdata !== e_wdata(e))) begin
          errors++;
          $display("FAIL adaptor_req: addr=%h rd=%0b wr=%0b wdata=%h, required addr=%h wr=%0b wdata=%h",
                   bus.mem_address, bus.mem_read, bus.mem_write, bus.mem_wdata, e_addr(e), e_wr(e), e_wdata(e));
        end
      end
      busy_cnt++;
      if (busy_cnt == lat) begin
        bus.mem_resp  = 1'b1;
        bus.mem_rdata = mem_line(bus.mem_address);
      end else begin
        bus.mem_resp = 1'b0;
      end
    end else begin
      busy_cnt     = 0;
      bus.mem_resp = spur;
      if (spur) bus.mem_rdata = '1;
    end
  end

  // ---------------- response monitor ----------------
  always @(negedge clk) begin
    logic [EW-1:0] e;
    if (prev_resp) begin
      checks++;
      if (bus.i_resp || bus.d_resp) begin
        errors++;
        $display("FAIL resp_width: i_resp=%0b d_resp=%0b one cycle after a resp, required 0", bus.i_resp, bus.d_resp);
      end
    end
    prev_resp = bus.i_resp || bus.d_resp;
    if (bus.i_resp || bus.d_resp) begin
      checks++;
      if (bus.i_resp && bus.d_resp) begin
        errors++;
        $display("FAIL resp_both: i_resp=1 d_resp=1, required only one");
      end else if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL resp_unexpected: i_resp=%0b d_resp=%0b, required no resp", bus.i_resp, bus.d_resp);
      end else begin
        e = exp_q.pop_front();
        if (bus.d_resp !== e_client(e)) begin
          errors++;
          $display("FAIL resp_client: d_resp=%0b, required client d=%0b (addr %h)", bus.d_resp, e_client(e), e_addr(e));
        end else if (e_client(e)) begin
          if (bus.d_rdata !== mem_line(e_addr(e)) || bus.i_rdata !== last_i) begin
            errors++;
            $display("FAIL d_rdata: d=%h i=%h, required d=%h i=%h", bus.d_rdata, bus.i_rdata, mem_line(e_addr(e)), last_i);
          end
          last_d = mem_line(e_addr(e));
        end else begin
          if (bus.i_rdata !== mem_line(e_addr(e)) || bus.d_rdata !== last_d) begin
            errors++;
            $display("FAIL i_rdata: i=%h d=%h, required i=%h d=%h", bus.i_rdata, bus.d_rdata, mem_line(e_addr(e)), last_d);
          end
          last_i = mem_line(e_addr(e));
        end
      end
    end
  end

  // ---------------- client driver tasks ----------------
  task automatic icache_read(input logic [ADDR_W-1:0] a);
    int n;
    bus.i_address = a;
    bus.i_read    = 1'b1;
    n = 0;
    do begin @(negedge clk); n++; end while (!bus.i_resp && n < 200);
    checks++;
    if (!bus.i_resp) begin errors++; $display("FAIL icache_timeout: no i_resp in %0d cycles, required a resp", n); end
    bus.i_read = 1'b0;
  endtask

  task automatic dcache_op(input logic wr, input logic [ADDR_W-1:0] a, input logic [LINE_W-1:0] w);
    int n;
    bus.d_address = a;
    bus.d_wdata   = w;
    bus.d_read    = ~wr;
    bus.d_write   = wr;
    n = 0;
    do begin @(negedge clk); n++; end while (!bus.d_resp && n < 200);
    checks++;
    if (!bus.d_resp) begin errors++; $display("FAIL dcache_timeout: no d_resp in %0d cycles, required a resp", n); end
    bus.d_read  = 1'b0;
    bus.d_write = 1'b0;
  endtask

  task automatic dcache_read2(input logic [ADDR_W-1:0] a0, input logic [ADDR_W-1:0] a1);
    int n;
    bus.d_address = a0;
    bus.d_read    = 1'b1;
    n = 0;
    do begin @(negedge clk); n++; end while (!bus.d_resp && n < 200);
    checks++;
    if (!bus.d_resp) begin errors++; $display("FAIL dcache_b2b_first: no d_resp in %0d cycles, required a resp", n); end
    bus.d_address = a1;
    n = 0;
    do begin @(negedge clk); n++; end while (!bus.d_resp && n < 200);
    checks++;
    if (!bus.d_resp) begin errors++; $display("FAIL dcache_b2b_second: no d_resp in %0d cycles, required a resp", n); end
    bus.d_read = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset;
    reset_n = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (state !== 2'd0) begin errors++; $display("FAIL reset_state: got %0d, required 0", state); end
    checks++; if (bus.mem_read !== 1'b0 || bus.mem_write !== 1'b0) begin errors++; $display("FAIL reset_mem_rw: rd=%0b wr=%0b, required 0 0", bus.mem_read, bus.mem_write); end
    checks++; if (bus.mem_address !== '0) begin errors++; $display("FAIL reset_mem_address: got %h, required 0", bus.mem_address); end
    checks++; if (bus.mem_wdata !== '0) begin errors++; $display("FAIL reset_mem_wdata: got %h, required 0", bus.mem_wdata); end
    checks++; if (bus.i_resp !== 1'b0 || bus.d_resp !== 1'b0) begin errors++; $display("FAIL reset_resp: i=%0b d=%0b, required 0 0", bus.i_resp, bus.d_resp); end
    checks++; if (bus.i_rdata !== '0 || bus.d_rdata !== '0) begin errors++; $display("FAIL reset_rdata: i=%h d=%h, required 0", bus.i_rdata, bus.d_rdata); end
    reset_n = 1'b1;
    @(negedge clk);
    checks++; if (state !== 2'd0) begin errors++; $display("FAIL reset_release_state: got %0d, required 0", state); end
  endtask

  task automatic test_icache_read;
    lat = 5;
    exp_q.push_back(mk_entry(1'b0, 1'b0, 32'h0000_0040, '0));
    icache_read(32'h0000_0040);
    checks++; if (bus.i_rdata !== {32{8'hA5}}) begin errors++; $display("FAIL icache_line: got %h, required a5..a5", bus.i_rdata); end
  endtask

  task automatic test_dcache_write;
    int n;
    logic [LINE_W-1:0] w;
    w = {4{64'h0123_4567_89AB_CDEF}};
    lat = 6;
    exp_q.push_back(mk_entry(1'b1, 1'b1, 32'h0000_1000, w));
    bus.d_address = 32'h0000_1000;
    bus.d_wdata   = w;
    bus.d_write   = 1'b1;
    n = 0;
    do begin @(negedge clk); n++; end while (!bus.mem_write && n < 50);
    checks++; if (!bus.mem_write) begin errors++; $display("FAIL dwrite_start: mem_write=0 after %0d cycles, required 1", n); end
    @(negedge clk);
    bus.d_wdata   = ~w;
    bus.d_address = 32'hFFFF_0000;
    n = 0;
    while (!bus.d_resp && n < 200) begin @(negedge clk); n++; end
    checks++; if (!bus.d_resp) begin errors++; $display("FAIL dwrite_timeout: no d_resp, required a resp"); end
    bus.d_write = 1'b0;
  endtask

  task automatic test_simultaneous;
    lat = $urandom_range(1, 6);
`ifdef CACHE_ARB_RR_EN
    exp_q.push_back(mk_entry(1'b0, 1'b0, 32'h0000_0080, '0));
    exp_q.push_back(mk_entry(1'b1, 1'b0, 32'h0000_2000, '0));
`else
    exp_q.push_back(mk_entry(1'b1, 1'b0, 32'h0000_2000, '0));
    exp_q.push_back(mk_entry(1'b0, 1'b0, 32'h0000_0080, '0));
`endif
    fork
      icache_read(32'h0000_0080);
      dcache_op(1'b0, 32'h0000_2000, '0);
    join
  endtask

  task automatic test_back_to_back;
    lat = $urandom_range(1, 6);
    exp_q.push_back(mk_entry(1'b1, 1'b0, 32'h0000_0100, '0));
`ifdef CACHE_ARB_RR_EN
    exp_q.push_back(mk_entry(1'b0, 1'b0, 32'h0000_01C0, '0));
    exp_q.push_back(mk_entry(1'b1, 1'b0, 32'h0000_0120, '0));
`else
    exp_q.push_back(mk_entry(1'b1, 1'b0, 32'h0000_0120, '0));
    exp_q.push_back(mk_entry(1'b0, 1'b0, 32'h0000_01C0, '0));
`endif
    fork
      dcache_read2(32'h0000_0100, 32'h0000_0120);
      begin @(negedge clk); icache_read(32'h0000_01C0); end
    join
  endtask

  task automatic test_reset_mid_busy;
    int n;
    lat = 20;
    exp_q.push_back(mk_entry(1'b0, 1'b0, 32'h0000_0300, '0));
    bus.i_address = 32'h0000_0300;
    bus.i_read    = 1'b1;
    n = 0;
    do begin @(negedge clk); n++; end while (!bus.mem_read && n < 50);
    checks++; if (!bus.mem_read) begin errors++; $display("FAIL abort_start: mem_read=0 after %0d cycles, required 1", n); end
    @(negedge clk);
    reset_n     = 1'b0;
    bus.i_read  = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    checks++; if (state !== 2'd0) begin errors++; $display("FAIL abort_state: got %0d, required 0", state); end
    checks++; if (bus.mem_read !== 1'b0 || bus.mem_write !== 1'b0) begin errors++; $display("FAIL abort_mem_rw: rd=%0b wr=%0b, required 0 0", bus.mem_read, bus.mem_write); end
    checks++; if (bus.i_rdata !== '0 || bus.d_rdata !== '0 || bus.mem_address !== '0) begin errors++; $display("FAIL abort_regs: i=%h d=%h addr=%h, required 0", bus.i_rdata, bus.d_rdata, bus.mem_address); end
    if (exp_q.size() > 0) exp_q.delete(0);
    last_i = '0;
    last_d = '0;
    repeat (3) @(negedge clk);
    lat = 3;
    exp_q.push_back(mk_entry(1'b0, 1'b0, 32'h0000_0340, '0));
    icache_read(32'h0000_0340);
  endtask

  task automatic test_spurious_resp;
    repeat (2) @(negedge clk);
    spur = 1'b1;
    repeat (3) @(negedge clk);
    spur = 1'b0;
    repeat (2) @(negedge clk);
    checks++; if (state !== 2'd0) begin errors++; $display("FAIL spurious_state: got %0d, required 0", state); end
    checks++; if (bus.i_rdata !== last_i || bus.d_rdata !== last_d) begin errors++; $display("FAIL spurious_rdata: i=%h d=%h, required i=%h d=%h", bus.i_rdata, bus.d_rdata, last_i, last_d); end
  endtask

  task automatic test_random_single;
    logic [ADDR_W-1:0] a;
    logic [LINE_W-1:0] w;
    int kind;
    for (int k = 0; k < 6; k++) begin
      lat  = $urandom_range(1, 7);
      a    = {$urandom_range(0, 32'hFFFF), 5'b0} & 32'h001F_FFE0;
      w    = {8{$urandom()}};
      kind = $urandom_range(0, 2);
      if (kind == 0) begin
        exp_q.push_back(mk_entry(1'b0, 1'b0, a, '0));
        icache_read(a);
      end else begin
        exp_q.push_back(mk_entry(1'b1, kind == 2, a, w));
        dcache_op(kind == 2, a, w);
      end
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.i_address = '0; bus.i_read = 1'b0;
    bus.d_address = '0; bus.d_read = 1'b0; bus.d_write = 1'b0; bus.d_wdata = '0;
    bus.mem_rdata = '0; bus.mem_resp = 1'b0;
    test_reset();
    test_icache_read();
    @(negedge clk);
    test_dcache_write();
    @(negedge clk);
    test_simultaneous();
    @(negedge clk);
    test_back_to_back();
    @(negedge clk);
    test_reset_mid_busy();
    test_spurious_resp();
    test_random_single();
    repeat (3) @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin errors++; $display("FAIL scoreboard_drain: %0d entries left, required 0", exp_q.size()); end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
